// File: rtl/isp_loader_pkg.sv
// isp_loader_pkg: shared FSM states, header field sizes and the default sync byte.
package isp_loader_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_ADDR,
    ST_DATA,
    ST_CSUM,
    ST_DONE
  } state_t;
  localparam int LEN_BYTES = 2;
  localparam int ADDR_BYTES = 4;
  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;
endpackage

// File: rtl/isp_word_assembler.sv
// isp_word_assembler: shifts bytes LSB-first into a word and flags each completed word.
module isp_word_assembler #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  strobe,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  done,
  output logic                  last
);
  localparam int BPW = DATA_WIDTH / 8;
  localparam int LW = $clog2(BPW + 1);
  logic [LW-1:0] lane;
  assign last = lane == LW'(BPW - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      word <= '0;
      lane <= '0;
      done <= 1'b0;
    end else if (clear) begin
      word <= '0;
      lane <= '0;
      done <= 1'b0;
    end else begin
      done <= strobe && last;
      if (strobe) begin
        word <= DATA_WIDTH'({byte_in, word} >> 8);
        lane <= last ? '0 : lane + 1'b1;
      end
    end
endmodule

// File: rtl/isp_loader.sv
// isp_loader: framed byte-stream ISP master; define ISP_LOADER_CHECKSUM_EN to require a trailing checksum byte.
module isp_loader
  import isp_loader_pkg::*;
#(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDRESS_BITS   = 20,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic                    isp_write,
  output logic [ADDRESS_BITS-1:0] isp_address,
  output logic [DATA_WIDTH-1:0]   isp_data,
  output logic                    start,
  output logic [ADDRESS_BITS-1:0] prog_address,
  output logic                    core_hold,
  output logic                    busy,
  output logic                    error
);
  localparam int BPW = DATA_WIDTH / 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef ISP_LOADER_CHECKSUM_EN
  localparam state_t TAIL = ST_CSUM;
`else
  localparam state_t TAIL = ST_DONE;
`endif
  state_t state;
  logic [1:0] hdr_cnt;
  logic [15:0] len, words_left;
  logic [ADDRESS_BITS-1:0] addr_base, addr_nx;
  logic [TW-1:0] idle_cnt;
  logic active, tmo, strobe, clear, last_lane;
  assign active = state != ST_IDLE && state != ST_DONE;
  assign tmo = active && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
  assign strobe = byte_valid && state == ST_DATA && !tmo;
  assign clear = state != ST_DATA || tmo;
  assign busy = state != ST_IDLE;
  assign addr_nx = addr_base | ADDRESS_BITS'(32'(byte_in) << {hdr_cnt, 3'b000});
  isp_word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .strobe (strobe),
    .byte_in(byte_in),
    .word   (isp_data),
    .done   (isp_write),
    .last   (last_lane)
  );
`ifdef ISP_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  always_ff @(posedge clock or posedge reset)
    if (reset) sum <= '0;
    else if (state == ST_IDLE) sum <= '0;
    else if (byte_valid && !tmo && (state == ST_LEN || state == ST_ADDR || state == ST_DATA))
      sum <= sum + byte_in;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      hdr_cnt <= '0;
      len <= '0;
      words_left <= '0;
      addr_base <= '0;
      idle_cnt <= '0;
      isp_address <= '0;
      prog_address <= '0;
      start <= 1'b0;
      core_hold <= 1'b0;
      error <= 1'b0;
    end else begin
      start <= 1'b0;
      idle_cnt <= (!active || byte_valid) ? '0 : idle_cnt + 1'b1;
      if (isp_write) isp_address <= isp_address + ADDRESS_BITS'(BPW);
      if (tmo) begin
        state <= ST_IDLE;
        error <= 1'b1;
        core_hold <= 1'b0;
      end else begin
        case (state)
          ST_IDLE:
            if (byte_valid && byte_in == SYNC_BYTE) begin
              state <= ST_LEN;
              error <= 1'b0;
              core_hold <= 1'b1;
              hdr_cnt <= '0;
              addr_base <= '0;
            end
          ST_LEN:
            if (byte_valid) begin
              len <= {byte_in, len[15:8]};
              hdr_cnt <= hdr_cnt == 2'(LEN_BYTES - 1) ? '0 : hdr_cnt + 1'b1;
              if (hdr_cnt == 2'(LEN_BYTES - 1)) state <= ST_ADDR;
            end
          ST_ADDR:
            if (byte_valid) begin
              addr_base <= addr_nx;
              hdr_cnt <= hdr_cnt + 1'b1;
              if (hdr_cnt == 2'(ADDR_BYTES - 1)) begin
                isp_address <= addr_nx;
                prog_address <= addr_nx;
                words_left <= len;
                state <= len != 0 ? ST_DATA : TAIL;
                start <= len == 0 && TAIL == ST_DONE;
              end
            end
          ST_DATA:
            if (byte_valid && last_lane) begin
              words_left <= words_left - 1'b1;
              if (words_left == 16'd1) begin
                state <= TAIL;
                start <= TAIL == ST_DONE;
              end
            end
`ifdef ISP_LOADER_CHECKSUM_EN
          ST_CSUM:
            if (byte_valid) begin
              if (byte_in == sum) begin
                state <= ST_DONE;
                start <= 1'b1;
              end else begin
                state <= ST_IDLE;
                error <= 1'b1;
                core_hold <= 1'b0;
              end
            end
`endif
          ST_DONE: begin
            state <= ST_IDLE;
            core_hold <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            core_hold <= 1'b0;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_isp_loader.sv
// tb_isp_loader: directed frames for isp_loader with hand-computed writes, start and error results.
module tb_isp_loader;
  logic clock = 1'b0;
  logic reset, byte_valid, isp_write, start, core_hold, busy, error;
  logic [7:0] byte_in;
  logic [19:0] isp_address, prog_address;
  logic [31:0] isp_data;
  int n_chk = 0, n_fail = 0;
  int wn = 0, sn = 0, w0, s0;
  logic [19:0] wa[16];
  logic [31:0] wd[16];
  logic [19:0] sa = '0;
  logic [7:0] fr[$];
  always #5 clock = ~clock;
  isp_loader #(
    .DATA_WIDTH(32),
    .ADDRESS_BITS(20),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(40)
  ) dut (
    .clock(clock),
    .reset(reset),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .isp_write(isp_write),
    .isp_address(isp_address),
    .isp_data(isp_data),
    .start(start),
    .prog_address(prog_address),
    .core_hold(core_hold),
    .busy(busy),
    .error(error)
  );
  always @(negedge clock) begin
    if (isp_write && wn < 16) begin
      wa[wn] = isp_address;
      wd[wn] = isp_data;
      wn++;
    end
    if (start) begin
      sn++;
      sa = prog_address;
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    byte_in = b;
    byte_valid = 1'b1;
    @(negedge clock);
  endtask
  task automatic send(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask
  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask
  initial begin
    reset = 1'b1;
    byte_valid = 1'b0;
    byte_in = '0;
    repeat (2) @(negedge clock);
    chk("rst_write", isp_write, 0);
    chk("rst_addr", isp_address, 0);
    chk("rst_data", isp_data, 0);
    chk("rst_start", start, 0);
    chk("rst_prog", prog_address, 0);
    chk("rst_flags", {core_hold, busy, error}, 0);
    reset = 1'b0;
    idle(1);
    send_byte(8'hA5);
    chk("a_hold", {core_hold, busy}, 2'b11);
    fr = '{8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef ISP_LOADER_CHECKSUM_EN
    fr.push_back(8'hB9);
`endif
    send(fr);
    idle(3);
    chk("a_wn", wn, 2);
    chk("a_wa0", wa[0], 20'h00100);
    chk("a_wd0", wd[0], 32'h00000013);
    chk("a_wa1", wa[1], 20'h00104);
    chk("a_wd1", wd[1], 32'h00100093);
    chk("a_start", sn, 1);
    chk("a_prog", sa, 20'h00100);
    chk("a_flags", {core_hold, busy, error}, 0);
    fr = '{8'hA5, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
`ifdef ISP_LOADER_CHECKSUM_EN
    fr.push_back(8'h40);
`endif
    send(fr);
    idle(3);
    chk("len0_wn", wn, 2);
    chk("len0_start", sn, 2);
    chk("len0_prog", sa, 20'h00040);
    fr = '{8'hA5, 8'h02, 8'h00, 8'hFC, 8'hFF, 8'h0F, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef ISP_LOADER_CHECKSUM_EN
    fr.push_back(8'h70);
`endif
    send(fr);
    idle(3);
    chk("wrap_wn", wn, 4);
    chk("wrap_wa0", wa[2], 20'hFFFFC);
    chk("wrap_wd0", wd[2], 32'h44332211);
    chk("wrap_wa1", wa[3], 20'h00000);
    chk("wrap_wd1", wd[3], 32'h88776655);
    chk("wrap_start", sn, 3);
`ifdef ISP_LOADER_CHECKSUM_EN
    fr = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB8};
    send(fr);
    idle(3);
    chk("bad_wn", wn, 6);
    chk("bad_start", sn, 3);
    chk("bad_flags", {core_hold, busy, error}, 3'b001);
`endif
    w0 = wn;
    s0 = sn;
    fr = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'hAA, 8'hBB};
    send(fr);
    idle(60);
    chk("tmo_flags", {core_hold, busy, error}, 3'b001);
    chk("tmo_wn", wn, w0);
    chk("tmo_start", sn, s0);
    send_byte(8'hA5);
    chk("sync_clr", {core_hold, error}, 2'b10);
    fr = '{8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef ISP_LOADER_CHECKSUM_EN
    fr.push_back(8'h3C);
`endif
    send(fr);
    idle(3);
    chk("post_tmo_wn", wn, w0 + 1);
    chk("post_tmo_wa", wa[w0], 20'h00300);
    chk("post_tmo_wd", wd[w0], 32'hEFBEADDE);
    chk("post_tmo_start", sn, s0 + 1);
    chk("post_tmo_prog", sa, 20'h00300);
    w0 = wn;
    s0 = sn;
    fr = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h11, 8'h22};
    send(fr);
    reset = 1'b1;
    byte_valid = 1'b0;
    #1;
    chk("mid_rst_out", {isp_write, isp_address, isp_data, start, prog_address, core_hold, busy, error}, 0);
    @(negedge clock);
    reset = 1'b0;
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(2);
    chk("junk_busy", busy, 0);
    fr = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
`ifdef ISP_LOADER_CHECKSUM_EN
    fr.push_back(8'h11);
`endif
    send(fr);
    idle(3);
    chk("post_rst_wn", wn, w0 + 1);
    chk("post_rst_wa", wa[w0], 20'h00600);
    chk("post_rst_wd", wd[w0], 32'h04030201);
    chk("post_rst_start", sn, s0 + 1);
    chk("post_rst_prog", sa, 20'h00600);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
